// File: rtl/rv32i_pkg.sv
// rv32i_pkg - shared definitions for the RV32I load/store path.
//   lsu_state_t       : load/store unit FSM state encoding (IDLE/REQ/WAIT_R/DONE)
//   F3_*              : load/store funct3 encodings (bit 2 selects zero-extension)
//   BE_*              : decoder byte-enable patterns (access size, unshifted)
//   lsu_is_misaligned : true when a half/word access is off its natural boundary
//   lsu_align_offset  : byte offset forced onto the natural boundary of the access
package rv32i_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t LSU_IDLE   = 2'd0;
  localparam lsu_state_t LSU_REQ    = 2'd1;
  localparam lsu_state_t LSU_WAIT_R = 2'd2;
  localparam lsu_state_t LSU_DONE   = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic lsu_is_misaligned(input logic [3:0] be, input logic [1:0] off);
    case (be)
      BE_HALF: return off[0];
      BE_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] lsu_align_offset(input logic [3:0] be, input logic [1:0] off);
    case (be)
      BE_HALF: return {off[1], 1'b0};
      BE_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// load_extender - combinational lane extraction and sign/zero extension of a
// loaded bus word.
//   i_offset   : byte offset of the access inside the word (already aligned)
//   i_byte_en  : access size as decoder byte enable (0001/0011/1111)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   i_word     : raw 32-bit word from the data bus
//   o_result   : right-aligned, extended load result
module load_extender
  import rv32i_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_byte_en,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane(s) and extend to 32 bits.
  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    o_result = i_word;
    case (i_offset)
      2'b00:   w_byte = i_word[7:0];
      2'b01:   w_byte = i_word[15:8];
      2'b10:   w_byte = i_word[23:16];
      2'b11:   w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_offset[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
    case (i_byte_en)
      BE_BYTE: o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      BE_HALF: o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit - single-outstanding load/store engine between the execute
// stage and a request/grant data bus.
//   Upstream : clk_i, rst_n_i, valid_i, mem_wr_en_i, byte_en_i, funct3_i,
//              addr_i, wr_data_i -> busy_o, done_o, rd_data_o, misaligned_o
//   Bus      : dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o
//              <- dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with a misaligned_o pulse; otherwise the offset is silently forced
// onto the natural boundary and misaligned_o stays 0.
module load_store_unit
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  input  logic        mem_wr_en_i,
  input  logic [3:0]  byte_en_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rd_data_o,
  output logic        misaligned_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  lsu_state_t  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rd_data;
  logic [3:0]  r_be;
  logic [3:0]  r_size;
  logic [1:0]  r_off;
  logic        r_we;
  logic        r_unsigned;

  logic        w_valid_access;
  logic        w_accept;
  logic        w_misaligned;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;
  logic        w_unused_funct3;

  // Only funct3[2] matters here; size comes from the byte enable.
  assign w_unused_funct3 = ^funct3_i[1:0];

  // Gated by rst_n_i so busy_o reads 0 while reset is held.
  assign w_valid_access = rst_n_i & valid_i & (byte_en_i != BE_NONE) & (r_state == LSU_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misaligned;
  assign w_misaligned = lsu_is_misaligned(byte_en_i, addr_i[1:0]);
  assign w_off        = addr_i[1:0];
  assign misaligned_o = r_misaligned;

  // One-cycle rejection pulse for an off-boundary access.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_valid_access & w_misaligned;
    end
  end
`else
  assign w_misaligned = 1'b0;
  assign w_off        = lsu_align_offset(byte_en_i, addr_i[1:0]);
  assign misaligned_o = 1'b0;
`endif

  assign w_accept = w_valid_access & ~w_misaligned;

  // Replicate store data so the active lanes carry it whatever the offset.
  always_comb begin
    w_wdata = wr_data_i;
    case (byte_en_i)
      BE_BYTE: w_wdata = {4{wr_data_i[7:0]}};
      BE_HALF: w_wdata = {2{wr_data_i[15:0]}};
      default: w_wdata = wr_data_i;
    endcase
  end

  load_extender u_load_extender (
    .i_offset   (r_off),
    .i_byte_en  (r_size),
    .i_unsigned (r_unsigned),
    .i_word     (dmem_rdata_i),
    .o_result   (w_ext)
  );

  // Request capture, bus handshake sequencing and load result register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= LSU_IDLE;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_rd_data  <= 32'h0000_0000;
      r_be       <= 4'b0000;
      r_size     <= 4'b0000;
      r_off      <= 2'b00;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_addr     <= {addr_i[31:2], 2'b00};
            r_wdata    <= w_wdata;
            r_be       <= byte_en_i << w_off;
            r_size     <= byte_en_i;
            r_off      <= w_off;
            r_we       <= mem_wr_en_i;
            r_unsigned <= funct3_i[2];
            r_state    <= LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (dmem_gnt_i) begin
            r_state <= r_we ? LSU_DONE : LSU_WAIT_R;
          end
        end
        LSU_WAIT_R: begin
          if (dmem_rvalid_i) begin
            r_rd_data <= w_ext;
            r_state   <= LSU_DONE;
          end
        end
        LSU_DONE: r_state <= LSU_IDLE;
        default:  r_state <= LSU_IDLE;
      endcase
    end
  end

  assign busy_o       = (r_state == LSU_REQ) | (r_state == LSU_WAIT_R) | w_valid_access;
  assign done_o       = (r_state == LSU_DONE);
  assign rd_data_o    = r_rd_data;
  assign dmem_req_o   = (r_state == LSU_REQ);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit - directed self-checking bench for load_store_unit.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned store step.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic        mem_wr_en_i;
  logic [3:0]  byte_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rd_data_o;
  logic        misaligned_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .valid_i       (valid_i),
    .mem_wr_en_i   (mem_wr_en_i),
    .byte_en_i     (byte_en_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .wr_data_i     (wr_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rd_data_o     (rd_data_o),
    .misaligned_o  (misaligned_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, busy_o},       32'd0);
    check({tag, "_done"},  {31'd0, done_o},       32'd0);
    check({tag, "_rd"},    rd_data_o,             32'd0);
    check({tag, "_mis"},   {31'd0, misaligned_o}, 32'd0);
    check({tag, "_req"},   {31'd0, dmem_req_o},   32'd0);
    check({tag, "_we"},    {31'd0, dmem_we_o},    32'd0);
    check({tag, "_addr"},  dmem_addr_o,           32'd0);
    check({tag, "_be"},    {28'd0, dmem_be_o},    32'd0);
    check({tag, "_wdata"}, dmem_wdata_o,          32'd0);
  endtask

  // Starts at a negedge, grants after 'waits' idle REQ cycles, returns rdata
  // one cycle after the grant, ends at a negedge after done_o has dropped.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [3:0] be,
                          input logic [2:0] f3, input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd);
    valid_i = 1'b1; mem_wr_en_i = 1'b0; byte_en_i = be; funct3_i = f3; addr_i = addr;
    #1 check({tag, "_busy_acc"}, {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0; addr_i = 32'hFFFF_FFFF; byte_en_i = 4'b0000;
    for (int i = 0; i <= waits; i++) begin
      check({tag, "_req"},  {31'd0, dmem_req_o}, 32'd1);
      check({tag, "_addr"}, dmem_addr_o, exp_addr);
      check({tag, "_be"},   {28'd0, dmem_be_o}, {28'd0, exp_be});
      check({tag, "_we"},   {31'd0, dmem_we_o}, 32'd0);
      if (i == waits) dmem_gnt_i = 1'b1;
      @(negedge clk_i);
    end
    dmem_gnt_i = 1'b0;
    check({tag, "_wait_req"},  {31'd0, dmem_req_o}, 32'd0);
    check({tag, "_wait_busy"}, {31'd0, busy_o},     32'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_rd"},   rd_data_o, exp_rd);
    @(negedge clk_i);
    check({tag, "_done_off"}, {31'd0, done_o}, 32'd0);
    check({tag, "_rd_hold"},  rd_data_o, exp_rd);
    check({tag, "_idle"},     {31'd0, busy_o}, 32'd0);
  endtask

  // Store with immediate grant; exp_mask selects the lanes that must carry data.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic [2:0] f3, input logic [31:0] data,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_mask, input logic [31:0] exp_lanes);
    valid_i = 1'b1; mem_wr_en_i = 1'b1; byte_en_i = be; funct3_i = f3;
    addr_i = addr; wr_data_i = data;
    #1 check({tag, "_busy_acc"}, {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0; wr_data_i = 32'h0;
    check({tag, "_req"},   {31'd0, dmem_req_o}, 32'd1);
    check({tag, "_we"},    {31'd0, dmem_we_o},  32'd1);
    check({tag, "_addr"},  dmem_addr_o, exp_addr);
    check({tag, "_be"},    {28'd0, dmem_be_o}, {28'd0, exp_be});
    check({tag, "_wdata"}, dmem_wdata_o & exp_mask, exp_lanes);
    check({tag, "_nodone"}, {31'd0, done_o}, 32'd0);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check({tag, "_done"},     {31'd0, done_o},     32'd1);
    check({tag, "_done_req"}, {31'd0, dmem_req_o}, 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0; valid_i = 1'b0; mem_wr_en_i = 1'b0; byte_en_i = 4'b0000;
    funct3_i = 3'b000; addr_i = 32'h0; wr_data_i = 32'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;

    // Reset values.
    @(negedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Stray grant/rvalid in IDLE and a zero byte-enable request are ignored.
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    valid_i = 1'b1; byte_en_i = 4'b0000; addr_i = 32'h44;
    #1 check("be0_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    check("be0_req",  {31'd0, dmem_req_o}, 32'd0);
    check("be0_done", {31'd0, done_o},     32'd0);
    check("be0_rd",   rd_data_o,           32'd0);
    valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    @(negedge clk_i);

    // SW 0x104: done_o in cycle 2.
    run_store("sw", 32'h0000_0104, 4'b1111, 3'b010, 32'hDEAD_BEEF,
              32'h0000_0104, 4'b1111, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    // New request presented during DONE must not be taken.
    valid_i = 1'b1; mem_wr_en_i = 1'b1; byte_en_i = 4'b1111; addr_i = 32'h600;
    @(posedge clk_i);
    #1;
    check("done_noacc_req",  {31'd0, dmem_req_o}, 32'd0);
    check("done_noacc_done", {31'd0, done_o},     32'd0);
    @(negedge clk_i);
    valid_i = 1'b0; byte_en_i = 4'b0000;
    @(negedge clk_i);
    check("done_noacc_idle", {31'd0, dmem_req_o}, 32'd0);

    // Byte loads, signed and unsigned, top lane.
    run_load("lb",  32'h0000_0203, 4'b0001, 3'b000, 0, 32'h80FF_FFFF,
             32'h0000_0200, 4'b1000, 32'hFFFF_FF80);
    run_load("lbu", 32'h0000_0203, 4'b0001, 3'b100, 0, 32'h80FF_FFFF,
             32'h0000_0200, 4'b1000, 32'h0000_0080);
    // Half loads with a 3-cycle grant delay.
    run_load("lh",  32'h0000_0302, 4'b0011, 3'b001, 3, 32'h8001_1234,
             32'h0000_0300, 4'b1100, 32'hFFFF_8001);
    run_load("lhu", 32'h0000_0302, 4'b0011, 3'b101, 1, 32'h8001_1234,
             32'h0000_0300, 4'b1100, 32'h0000_8001);
    run_load("lw",  32'h0000_0308, 4'b1111, 3'b010, 0, 32'h1234_5678,
             32'h0000_0308, 4'b1111, 32'h1234_5678);

    // SH to an odd address.
`ifdef LSU_MISALIGN_TRAP_EN
    valid_i = 1'b1; mem_wr_en_i = 1'b1; byte_en_i = 4'b0011; funct3_i = 3'b001;
    addr_i = 32'h0000_0401; wr_data_i = 32'h0000_ABCD;
    @(negedge clk_i);
    valid_i = 1'b0; byte_en_i = 4'b0000;
    check("sh_mis_pulse", {31'd0, misaligned_o}, 32'd1);
    check("sh_mis_noreq", {31'd0, dmem_req_o},   32'd0);
    @(negedge clk_i);
    check("sh_mis_off",    {31'd0, misaligned_o}, 32'd0);
    check("sh_mis_nodone", {31'd0, done_o},       32'd0);
    check("sh_mis_noreq2", {31'd0, dmem_req_o},   32'd0);
`else
    run_store("sh", 32'h0000_0401, 4'b0011, 3'b001, 32'h0000_ABCD,
              32'h0000_0400, 4'b0011, 32'h0000_FFFF, 32'h0000_ABCD);
    check("sh_nomis", {31'd0, misaligned_o}, 32'd0);
    @(negedge clk_i);
`endif

    // SB to the top lane.
    run_store("sb", 32'h0000_0107, 4'b0001, 3'b000, 32'h0000_00A5,
              32'h0000_0104, 4'b1000, 32'hFF00_0000, 32'hA500_0000);
    @(negedge clk_i);

    // Reset while waiting for load data.
    valid_i = 1'b1; mem_wr_en_i = 1'b0; byte_en_i = 4'b1111; funct3_i = 3'b010;
    addr_i = 32'h0000_0500;
    @(negedge clk_i);
    valid_i = 1'b0; byte_en_i = 4'b0000; dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check("rst_pre_busy", {31'd0, busy_o}, 32'd1);
    check("rst_pre_rd",   rd_data_o, 32'h1234_5678);
    rst_n_i = 1'b0;
    #1 check_all_zero("rst_wait");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    check("post_rst_done", {31'd0, done_o}, 32'd0);
    check("post_rst_rd",   rd_data_o, 32'd0);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    check("post_rst_done2", {31'd0, done_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk_i  in  1  single clock; all state rising-edge.
REQ-002 rst_n_i  in  1  asynchronous, active-low reset.
REQ-003 valid_i  in  1  execute stage presents a load/store this cycle.
REQ-004 mem_wr_en_i  in  1  1 = store, 0 = load (decoder memory write enable).
REQ-005 byte_en_i  in  4  decoder byte enable: 0001 byte, 0011 half, 1111 word; 0000 = no access.
REQ-006 funct3_i  in  3  instruction funct3; bit 2 set = zero-extend load (LBU/LHU).
REQ-007 addr_i  in  32  ALU-computed effective byte address.
REQ-008 wr_data_i  in  32  store data, right-aligned (rs2).
REQ-009 busy_o  out  1  stall request to upstream stages.
REQ-010 done_o  out  1  one-cycle pulse: access complete.
REQ-011 rd_data_o  out  32  extended load result, valid with done_o, held until next done_o.
REQ-012 misaligned_o  out  1  one-cycle pulse: access rejected (see Configuration).
REQ-013 dmem_req_o  out  1  bus request.
REQ-014 dmem_we_o  out  1  bus write.
REQ-015 dmem_addr_o  out  32  word address, bits[1:0] = 00.
REQ-016 dmem_be_o  out  4  byte lanes, byte_en_i shifted left by addr[1:0].
REQ-017 dmem_wdata_o  out  32  store data replicated/shifted into active lanes.
REQ-018 dmem_gnt_i  in  1  bus accepts request this cycle.
REQ-019 dmem_rvalid_i  in  1  load data valid.
REQ-020 dmem_rdata_i  in  32  load word.

Function
REQ-021 FSM states IDLE, REQ, WAIT_R, DONE SHALL be used.
REQ-022 IDLE: valid_i=1 and byte_en_i!=0 SHALL register all request fields and go to REQ; valid_i with byte_en_i=0 SHALL be ignored.
REQ-023 REQ: dmem_req_o=1 with registered fields stable until dmem_gnt_i; on gnt, store -> DONE, load -> WAIT_R.
REQ-024 WAIT_R: dmem_req_o=0; on dmem_rvalid_i, extracted/extended data SHALL be registered into rd_data_o, go to DONE.
REQ-025 DONE: done_o=1 for exactly one cycle, then IDLE; new valid_i SHALL NOT be accepted in DONE.
REQ-026 busy_o SHALL be 1 in REQ and WAIT_R, and combinationally 1 in IDLE when an access is being accepted.
REQ-027 Minimum latency: store valid_i cycle 0 -> done_o cycle 2; load -> done_o cycle 3 (gnt cycle 1, rvalid cycle 2).
REQ-028 Load extraction: byte/half selected by offset; sign-extend from bit 7/15 unless funct3_i[2]=1, then zero-extend; word passed unchanged.
REQ-029 dmem_rvalid_i outside WAIT_R and dmem_gnt_i outside REQ SHALL be ignored.

Reset
REQ-030 Asserting rst_n_i low SHALL force IDLE immediately, mid-transaction included, aborting any outstanding access.
REQ-031 Under reset all outputs SHALL be 0, including rd_data_o = 32'h0.

Configuration
REQ-032 With LSU_MISALIGN_TRAP_EN defined, half at odd offset or word at offset!=0 SHALL issue no bus request, pulse misaligned_o in the cycle after valid_i, and return to IDLE without done_o.
REQ-033 Without LSU_MISALIGN_TRAP_EN, misaligned_o SHALL be tied 0 and the offset SHALL be masked to natural alignment (half: addr[0]=0, word: addr[1:0]=0) before the access.

Structure
REQ-034 lsu_state_t and the load/store funct3 and byte-enable constants SHALL live in the shared rv32i_pkg package.
REQ-035 Lane extraction and extension SHALL be a combinational sub-module load_extender (offset, byte_en, unsigned, word in -> 32-bit result).

Verification
REQ-036 SW addr=0x104 data=0xDEADBEEF, gnt immediate -> dmem_addr 0x104, be 1111, wdata 0xDEADBEEF, done_o cycle 2.
REQ-037 LB addr=0x203, rdata=0x80FF_FFFF -> be 1000, rd_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 LH addr=0x302, rdata=0x8001_1234, gnt after 3 wait cycles -> be 1100, req held stable, rd_data_o=0xFFFF8001.
REQ-039 SH addr=0x401 data=0x0000ABCD: macro on -> misaligned_o pulse, no req; macro off -> addr 0x400, be 0011, wdata lanes 0xABCD.
REQ-040 rst_n_i low while in WAIT_R -> all outputs 0, IDLE; later rvalid ignored, no done_o.
